sbox_lookup_pipe: RTL and testbench
===================================

# sbox_lookup_pipe

Parametrised, programmable, pipelined S-box lookup engine for the DES datapath. It performs LANES independent 6-to-4-bit substitutions per beat; DES uses LANES=8, S1..S8. Every lane's table is writable at run time through a configuration port. Lookups stream through a 2-stage valid/ready pipeline between the expansion/key-XOR stage and the P-permutation stage.

## Interface

Parameters:
- LANES, default 8: number of independent S-box lanes; 1..8.
- LANE_W, default 3: width of cfg_lane. Must satisfy 2**LANE_W >= LANES.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts a beat this cycle.
- in_data  in  6*LANES  lane i address at bits [6i+5:6i].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts a beat this cycle.
- out_data  out  4*LANES  lane i result at bits [4i+3:4i].
- cfg_we  in  1  table write strobe, one entry per cycle.
- cfg_lane  in  LANE_W  lane to write. Values >= LANES are ignored.
- cfg_row  in  2  row index of the entry to write.
- cfg_col  in  4  column index of the entry to write.
- cfg_data  in  4  value to write.

## Operation

- Address mapping per lane, for a 6-bit address a:
  - row = {a[5], a[0]}
  - col = a[4:1]
  - entry index = row*16 + col
- Storage: LANES tables of 64 x 4-bit registers.
- Reset contents: entry k of every lane = k[3:0]. Example: a=6'b100001 gives row 3, col 0, index 48, so the lane returns 0.
- Configuration writes:
  - On a cycle with cfg_we=1 and cfg_lane < LANES, entry cfg_row*16+cfg_col of lane cfg_lane takes cfg_data at the clock edge.
  - If cfg_lane >= LANES, the write is dropped and no state changes.
  - Writes are never blocked and have no handshake.
- Pipeline stage S1: registers in_data plus a valid bit (s1_valid).
- Pipeline stage S2: registers the table lookup of the S1 address into out_data, plus out_valid.
- Advance rules:
  - s2_adv = s1_valid && (!out_valid || out_ready)
  - in_ready = !s1_valid || s2_adv
- Accept and pop:
  - An input beat is accepted when in_valid && in_ready.
  - An output beat is popped when out_valid && out_ready.
- Read/write ordering: the lookup uses the table contents before any write that lands on the same edge as the S1→S2 transfer. A write takes effect for transfers on later cycles.
- Stall: while out_valid && !out_ready, out_data and out_valid hold stable. S1 holds, and in_ready stays 0 if S1 is full.
- Bubbles: none are inserted; a continuous stream sustains 1 beat/cycle.
- Simultaneous pop and S1→S2 transfer: S2 loads the new beat and out_valid stays 1.
- Reset asserted mid-stream:
  - s1_valid and out_valid clear immediately, and any beats in flight are discarded.
  - Tables return to their reset contents.
  - out_data clears to 0.
- No other state exists: no counters and no error flags.

## Timing

- Reset values of outputs: in_ready=1, out_valid=0, out_data=0.
- After reset deassertion, in_ready=1 on the first cycle.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1, when out_ready was 1 or S2 was empty. Latency is 2 cycles from the in_valid cycle to the out_valid cycle.
- Throughput: 1 beat/cycle with out_ready held at 1.
- Ordering: beats leave in acceptance order. Maximum occupancy is 2 beats.
- in_ready depends combinationally on out_ready, but only through a single AND/OR.
- out_data and out_valid are driven directly from registers.

## Test plan

- Reset values: pulse rst_n low asynchronously, mid-cycle.
  - Required: in_ready=1, out_valid=0 and out_data=0 immediately.
  - Then send lane-0 address 6'b100001 with LANES=8. Required: lane 0 returns 0 (identity index 48 → 0). Address 6'b011110 returns 15.
- Programmed table: write lane 3 with the DES S4 table, 64 writes: row 0 = 7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, and rows 1–3 per the standard S4 table.
  - Addresses 6'b000000, 6'b000010, 6'b000001, 6'b100000, 6'b100001 on lane 3 must return 7, 13, 13, 10, 3.
- Streaming: 16 back-to-back beats with out_ready=1.
  - Required: outputs on 16 consecutive cycles, starting 2 cycles after the first accept, in order, with no gaps.
- Backpressure: drop out_ready for 5 cycles mid-stream.
  - Required: out_data stable and in_ready=0 after 2 beats are held.
  - After out_ready returns, no beat is lost or duplicated.
- Write/lookup collision: write lane 3, row 0, col 1 := 9 on the same edge that its lookup transfers S1→S2.
  - Required: that beat returns the old value 13; the next identical beat returns 9.
  - Also: cfg_lane=7 with LANES=6 changes nothing.
- Reset mid-operation: assert rst_n with 2 beats in flight and lane 3 programmed.
  - Required: out_valid falls immediately and no stale beat appears after release.
  - Lane 3, address 6'b000010 returns identity value 1.

Source files
------------

// File: rtl/sbox_lookup_pipe_if.sv
// Stream handshake bundle for the S-box lookup engine: 6-bit addresses in,
// 4-bit substitutions out, one group per lane.
interface sbox_lookup_pipe_if #(
  parameter int LANES = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [6*LANES-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*LANES-1:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sbox_lookup_pipe.sv
// Programmable, 2-stage pipelined S-box engine: LANES independent 6-to-4-bit
// substitutions per beat, each lane's 64-entry table writable at run time.
module sbox_lookup_pipe #(
  parameter int LANES  = 8,
  parameter int LANE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  sbox_lookup_pipe_if.slave bus,
  input  logic              cfg_we,
  input  logic [LANE_W-1:0] cfg_lane,
  input  logic [1:0]        cfg_row,
  input  logic [3:0]        cfg_col,
  input  logic [3:0]        cfg_data
);

  logic [3:0]         tbl_q [LANES][64];
  logic [3:0]         tbl_d [LANES][64];

  logic               s1_valid_q, s1_valid_d;
  logic [6*LANES-1:0] s1_data_q,  s1_data_d;
  logic               out_valid_q, out_valid_d;
  logic [4*LANES-1:0] out_data_q,  out_data_d;

  logic               s2_adv;
  logic               in_ready;
  logic               accept;
  logic [4*LANES-1:0] lookup;
  logic [5:0]         addr;

  assign s2_adv   = s1_valid_q && (!out_valid_q || bus.out_ready);
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Lookup reads the registered tables, so a write landing on the same edge
  // as the S1->S2 transfer is seen only by later transfers.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned and infers a latch.
    lookup = '0;
    addr   = '0;
    for (int i = 0; i < LANES; i++) begin
      addr = s1_data_q[6*i +: 6];
      lookup[4*i +: 4] = tbl_q[i][{addr[5], addr[0], addr[4:1]}];
    end
  end

  always_comb begin
    tbl_d = tbl_q;
    if (cfg_we && (int'(cfg_lane) < LANES)) begin
      tbl_d[cfg_lane][{cfg_row, cfg_col}] = cfg_data;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = bus.in_data;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      out_valid_d = 1'b1;
      out_data_d  = lookup;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: the tables are reset like any other flop because their identity
  // contents are architecturally visible right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < 64; k++) begin
          tbl_q[l][k] <= 4'(k);
        end
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_sbox_lookup_pipe.sv
// Scoreboard bench for sbox_lookup_pipe: expected words are queued at accept
// time from a table model and compared when the engine pops them.
module tb_sbox_lookup_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sbox_lookup_pipe_if #(.LANES(8)) bus ();
  sbox_lookup_pipe_if #(.LANES(6)) bus6 ();

  logic       cfg_we, cfg6_we;
  logic [2:0] cfg_lane, cfg6_lane;
  logic [1:0] cfg_row, cfg6_row;
  logic [3:0] cfg_col, cfg6_col;
  logic [3:0] cfg_data, cfg6_data;

  sbox_lookup_pipe #(.LANES(8), .LANE_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_row(cfg_row),
    .cfg_col(cfg_col), .cfg_data(cfg_data)
  );

  sbox_lookup_pipe #(.LANES(6), .LANE_W(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .bus(bus6),
    .cfg_we(cfg6_we), .cfg_lane(cfg6_lane), .cfg_row(cfg6_row),
    .cfg_col(cfg6_col), .cfg_data(cfg6_data)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;

  logic [31:0] exp_q[$];
  int          acc_cyc_q[$];
  int          pop_cyc_q[$];
  logic [31:0] last_pop;
  logic [3:0]  mdl [8][64];

  int s4 [64] = '{
     7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
    13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
    10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
     3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14
  };

  always @(posedge clk) cyc++;

  function automatic logic [31:0] model_lookup(input logic [47:0] d);
    logic [5:0] a;
    int row, col;
    model_lookup = '0;
    for (int i = 0; i < 8; i++) begin
      a   = d[6*i +: 6];
      row = 2 * int'(a[5]) + int'(a[0]);
      col = int'(a[4:1]);
      model_lookup[4*i +: 4] = mdl[i][row*16 + col];
    end
  endfunction

  task automatic model_reset;
    for (int l = 0; l < 8; l++)
      for (int k = 0; k < 64; k++)
        mdl[l][k] = 4'(k);
  endtask

  // Monitor: pop/compare first, then record this cycle's accept.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      logic [31:0] e;
      total++;
      pops++;
      pop_cyc_q.push_back(cyc);
      last_pop = bus.out_data;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected got=%h want=<no beat>", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          bad++;
          $display("FAIL pop_data got=%h want=%h", bus.out_data, e);
        end
      end
    end
    if (rst_n && bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model_lookup(bus.in_data));
      acc_cyc_q.push_back(cyc);
    end
  end

  task automatic drive_beat(input logic [47:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (t > 50) begin
        total++; bad++;
        $display("FAIL accept_timeout got=in_ready 0 want=in_ready 1");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain;
    int t;
    for (t = 0; t < 100; t++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    if (t >= 100) begin
      total++; bad++;
      $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
    end
  endtask

  task automatic cfg_write(input int lane, input int row, input int col, input logic [3:0] v);
    cfg_we   = 1'b1;
    cfg_lane = 3'(lane);
    cfg_row  = 2'(row);
    cfg_col  = 4'(col);
    cfg_data = v;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    mdl[lane][row*16 + col] = v;
  endtask

  task automatic lane_beat(input int lane, input logic [5:0] a);
    logic [47:0] d;
    d = '0;
    d[6*lane +: 6] = a;
    drive_beat(d);
    bus.in_valid = 1'b0;
    wait_drain;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h want=0", bus.out_data); end
    model_reset();
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", bus.in_ready); end
    @(posedge clk);
    #1;
    lane_beat(0, 6'b100001);
    total++; if (last_pop[3:0] !== 4'd0) begin bad++; $display("FAIL ident_100001 got=%0d want=0", last_pop[3:0]); end
    lane_beat(0, 6'b011110);
    total++; if (last_pop[3:0] !== 4'd15) begin bad++; $display("FAIL ident_011110 got=%0d want=15", last_pop[3:0]); end
  endtask

  task automatic test_program;
    logic [5:0] addrs [5] = '{6'b000000, 6'b000010, 6'b000001, 6'b100000, 6'b100001};
    logic [3:0] wants [5] = '{4'd7, 4'd13, 4'd13, 4'd10, 4'd3};
    for (int k = 0; k < 64; k++) cfg_write(3, k / 16, k % 16, 4'(s4[k]));
    for (int i = 0; i < 5; i++) begin
      lane_beat(3, addrs[i]);
      total++;
      if (last_pop[15:12] !== wants[i]) begin
        bad++;
        $display("FAIL s4_lookup_%0d got=%0d want=%0d", i, last_pop[15:12], wants[i]);
      end
    end
  endtask

  task automatic test_streaming;
    logic [47:0] d;
    acc_cyc_q.delete();
    pop_cyc_q.delete();
    for (int i = 0; i < 16; i++) begin
      d[31:0]  = $urandom();
      d[47:32] = 16'($urandom());
      drive_beat(d);
    end
    bus.in_valid = 1'b0;
    wait_drain;
    total++;
    if (pop_cyc_q.size() != 16) begin bad++; $display("FAIL stream_count got=%0d want=16", pop_cyc_q.size()); end
    for (int i = 0; i < 16 && i < pop_cyc_q.size(); i++) begin
      total++;
      if (pop_cyc_q[i] != acc_cyc_q[0] + 2 + i) begin
        bad++;
        $display("FAIL stream_timing_%0d got=cyc %0d want=cyc %0d", i, pop_cyc_q[i], acc_cyc_q[0] + 2 + i);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] held;
    int pops0;
    pops0 = pops;
    fork
      begin
        logic [47:0] d;
        for (int i = 0; i < 10; i++) begin
          d[31:0]  = $urandom();
          d[47:32] = 16'($urandom());
          drive_beat(d);
        end
        bus.in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        held = '0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i == 0) begin
            held = bus.out_data;
          end else begin
            total++;
            if (bus.out_data !== held || bus.out_valid !== 1'b1) begin
              bad++;
              $display("FAIL stall_hold_%0d got=%h/%b want=%h/1", i, bus.out_data, bus.out_valid, held);
            end
            total++;
            if (bus.in_ready !== 1'b0) begin
              bad++;
              $display("FAIL stall_in_ready_%0d got=%b want=0", i, bus.in_ready);
            end
          end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain;
    total++;
    if (pops - pops0 != 10) begin bad++; $display("FAIL bp_count got=%0d want=10", pops - pops0); end
  endtask

  task automatic test_collision;
    logic [47:0] d;
    d = '0;
    d[23:18] = 6'b000010;
    drive_beat(d);
    bus.in_valid = 1'b0;
    cfg_write(3, 0, 1, 4'd9);
    wait_drain;
    total++; if (last_pop[15:12] !== 4'd13) begin bad++; $display("FAIL collide_old got=%0d want=13", last_pop[15:12]); end
    lane_beat(3, 6'b000010);
    total++; if (last_pop[15:12] !== 4'd9) begin bad++; $display("FAIL collide_new got=%0d want=9", last_pop[15:12]); end
  endtask

  task automatic test_lane_range;
    cfg6_we = 1'b1; cfg6_lane = 3'd7; cfg6_row = 2'd0; cfg6_col = 4'd0; cfg6_data = 4'd5;
    @(posedge clk);
    #1 cfg6_we = 1'b0;
    bus6.in_valid = 1'b1;
    bus6.in_data  = '0;
    @(posedge clk);
    #1 bus6.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus6.out_valid !== 1'b1) begin bad++; $display("FAIL lanes6_valid got=%b want=1", bus6.out_valid); end
    total++; if (bus6.out_data !== 24'h0) begin bad++; $display("FAIL lanes6_ignored_write got=%h want=0", bus6.out_data); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midstream;
    logic [47:0] d;
    bus.out_ready = 1'b0;
    d = '0; d[23:18] = 6'b000000; drive_beat(d);
    d = '0; d[23:18] = 6'b000001; drive_beat(d);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready); end
    model_reset();
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale_%0d got=%b want=0", i, bus.out_valid); end
    end
    @(posedge clk);
    #1;
    lane_beat(3, 6'b000010);
    total++; if (last_pop[15:12] !== 4'd1) begin bad++; $display("FAIL midrst_ident got=%0d want=1", last_pop[15:12]); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus6.in_valid = 1'b0; bus6.in_data = '0; bus6.out_ready = 1'b1;
    cfg_we = 1'b0; cfg_lane = '0; cfg_row = '0; cfg_col = '0; cfg_data = '0;
    cfg6_we = 1'b0; cfg6_lane = '0; cfg6_row = '0; cfg6_col = '0; cfg6_data = '0;
    last_pop = '0;
    model_reset();

    test_reset();
    test_program();
    test_streaming();
    test_backpressure();
    test_collision();
    test_lane_range();
    test_reset_midstream();

    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
